// File: rtl/countdown_scheduler_if.sv
// Request/grant bundle between game-logic requesters (master) and the shared countdown engine (slave).
// The abort wire exists only when COUNTDOWN_ABORT_EN is defined.
interface countdown_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int TIME_W  = 11
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                      startOfFrame;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*TIME_W-1:0] req_time;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic                      busy;
  logic [ID_W-1:0]           active_id;
`ifdef COUNTDOWN_ABORT_EN
  logic                      abort;
`endif

  modport master (
`ifdef COUNTDOWN_ABORT_EN
    output abort,
`endif
    output startOfFrame, req, req_time,
    input  grant, done, busy, active_id
  );

  modport slave (
`ifdef COUNTDOWN_ABORT_EN
    input  abort,
`endif
    input  startOfFrame, req, req_time,
    output grant, done, busy, active_id
  );
endinterface

// File: rtl/countdown_scheduler.sv
// Round-robin shared frame countdown: grant one cycle after req, done one cycle after cnt reaches 0.
// Requesters wait (level req) while the engine is owned; COUNTDOWN_ABORT_EN adds an early-release abort.
module countdown_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIME_W  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_scheduler_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t             state, state_nxt;
  logic [TIME_W-1:0]  cnt, cnt_nxt;
  logic [ID_W-1:0]    last_id, last_id_nxt;
  logic [ID_W-1:0]    active_q, active_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [NUM_REQ-1:0] done_q, done_nxt;
  logic               busy_q, busy_nxt;
  logic [ID_W-1:0]    winner;
  logic               found;
  int                 idx;

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    last_id_nxt = last_id;
    active_nxt  = active_q;
    grant_nxt   = grant_q;
    done_nxt    = '0;
    busy_nxt    = busy_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = COUNT;
          grant_nxt  = NUM_REQ'(1) << winner;
          active_nxt = winner;
          cnt_nxt    = bus.req_time[winner*TIME_W +: TIME_W];
          busy_nxt   = 1'b1;
        end
      end
      COUNT: begin
`ifdef COUNTDOWN_ABORT_EN
        if (bus.abort) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
          last_id_nxt = active_q;
        end else
`endif
        if (cnt == '0) begin
          state_nxt   = IDLE;
          done_nxt    = NUM_REQ'(1) << active_q;
          grant_nxt   = '0;
          busy_nxt    = 1'b0;
          last_id_nxt = active_q;
        end else if (bus.startOfFrame) begin
          cnt_nxt = cnt - TIME_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // last_id resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      last_id  <= ID_W'(NUM_REQ - 1);
      active_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      last_id  <= last_id_nxt;
      active_q <= active_nxt;
      grant_q  <= grant_nxt;
      done_q   <= done_nxt;
      busy_q   <= busy_nxt;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = active_q;
endmodule

// File: tb/tb_countdown_scheduler.sv
// Randomized and directed bench for countdown_scheduler against a request-level reference model.
module tb_countdown_scheduler;
  localparam int NREQ = 4;
  localparam int TW   = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  countdown_scheduler_if #(.NUM_REQ(NREQ), .TIME_W(TW)) bus ();

  countdown_scheduler #(.NUM_REQ(NREQ), .TIME_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference: who owns the engine, frames left, last owner, pending done pulse.
  int m_owner, m_left, m_last, m_done, m_active;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_left   = 0;
    m_last   = NREQ - 1;
    m_done   = -1;
    m_active = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    m_done = -1;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (bus.req[c]) begin
          m_owner  = c;
          m_active = c;
          m_left   = int'(bus.req_time[c*TW +: TW]);
          break;
        end
      end
    end else begin
`ifdef COUNTDOWN_ABORT_EN
      if (bus.abort) begin
        m_last  = m_owner;
        m_owner = -1;
        return;
      end
`endif
      if (m_left == 0) begin
        m_done  = m_owner;
        m_last  = m_owner;
        m_owner = -1;
      end else if (bus.startOfFrame) begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("grant", 32'(bus.grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("done", 32'(bus.done), (m_done >= 0) ? (1 << m_done) : 0);
    chk("busy", 32'(bus.busy), (m_owner >= 0) ? 1 : 0);
    chk("active_id", 32'(bus.active_id), m_active);
  endtask

  task automatic set_time(input int i, input int v);
    bus.req_time[i*TW +: TW] = TW'(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] prev;
    logic [NREQ-1:0] gq[$];

    bus.startOfFrame = 1'b0;
    bus.req          = '0;
    bus.req_time     = '0;
`ifdef COUNTDOWN_ABORT_EN
    bus.abort        = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_active", 32'(bus.active_id), 0);
    reset = 1'b0;

    // Single request, SOF every 10 cycles
    bus.req = 4'b0001;
    set_time(0, 3);
    tick();
    chk("t1_grant", 32'(bus.grant), 1);
    bus.req = '0;
    n = 0;
    for (int c = 0; c < 45; c++) begin
      bus.startOfFrame = (c % 10 == 9);
      tick();
      if (bus.done[0]) n++;
    end
    bus.startOfFrame = 1'b0;
    chk("t1_done_count", n, 1);

    // Arbitration: req0 and req2 together
    do_reset();
    bus.req = 4'b0101;
    set_time(0, 1);
    set_time(2, 1);
    prev = '0;
    gq.delete();
    for (int c = 0; c < 60 && (bus.req != 0 || bus.busy); c++) begin
      bus.startOfFrame = c[0];
      tick();
      if (bus.grant != 0 && bus.grant != prev) gq.push_back(bus.grant);
      prev = bus.grant;
      bus.req = bus.req & ~bus.done;
    end
    bus.startOfFrame = 1'b0;
    chk("t2_grant_count", gq.size(), 2);
    if (gq.size() >= 2) begin
      chk("t2_first", 32'(gq[0]), 1);
      chk("t2_second", 32'(gq[1]), 4);
    end

    // Fairness: all held high with zero delay
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_time(i, 0);
    prev = '0;
    gq.delete();
    for (int c = 0; c < 40 && gq.size() < 5; c++) begin
      tick();
      if (bus.grant != 0 && prev == 0) gq.push_back(bus.grant);
      prev = bus.grant;
    end
    chk("t3_grant_count", gq.size(), 5);
    if (gq.size() == 5) begin
      chk("t3_g0", 32'(gq[0]), 1);
      chk("t3_g1", 32'(gq[1]), 2);
      chk("t3_g2", 32'(gq[2]), 4);
      chk("t3_g3", 32'(gq[3]), 8);
      chk("t3_g4", 32'(gq[4]), 1);
    end
    bus.req = '0;
    tick();
    tick();

    // D=0: done one cycle after grant, no SOF
    do_reset();
    bus.req = 4'b0001;
    set_time(0, 0);
    tick();
    bus.req = '0;
    tick();
    chk("t4_d0_done", 32'(bus.done), 1);

    // SOF on the grant edge is not counted
    tick();
    bus.req = 4'b0010;
    set_time(1, 1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    bus.req = '0;
    repeat (3) tick();
    chk("t4_sof_grant_busy", 32'(bus.busy), 1);
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    chk("t4_sof_still_busy", 32'(bus.busy), 1);
    tick();
    chk("t4_sof_done", 32'(bus.done), 2);
    tick();

    // Maximum delay: 2047 frames, no wrap
    bus.req = 4'b0001;
    set_time(0, 2047);
    bus.startOfFrame = 1'b1;
    tick();
    bus.req = '0;
    n = 0;
    for (int i = 1; i <= 2100; i++) begin
      tick();
      if (bus.done != 0) begin
        n = i;
        break;
      end
    end
    bus.startOfFrame = 1'b0;
    chk("t4_d2047_latency", n, 2048);
    tick();

    // Reset mid-count with cnt=5; req0 must be favoured afterwards
    do_reset();
    bus.req = 4'b0001;
    set_time(0, 0);
    tick();
    bus.req = '0;
    tick();
    tick();
    bus.req = 4'b0100;
    set_time(2, 8);
    bus.startOfFrame = 1'b1;
    tick();
    bus.req = '0;
    repeat (3) tick();
    bus.startOfFrame = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_grant", 32'(bus.grant), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_active", 32'(bus.active_id), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0011;
    set_time(0, 1);
    set_time(1, 1);
    tick();
    chk("t5_favour_req0", 32'(bus.grant), 1);
    bus.req = '0;
    repeat (3) tick();

`ifdef COUNTDOWN_ABORT_EN
    // Abort during COUNT releases the engine without done
    do_reset();
    bus.req = 4'b0010;
    set_time(1, 5);
    set_time(2, 1);
    tick();
    bus.req = 4'b0110;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t6_abort_grant", 32'(bus.grant), 0);
    chk("t6_abort_done", 32'(bus.done), 0);
    bus.req = 4'b0100;
    tick();
    chk("t6_next_grant", 32'(bus.grant), 4);
    bus.req = '0;
    repeat (3) tick();
`endif

    // Randomized traffic with occasional mid-run resets
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      bus.req = NREQ'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) set_time(i, $urandom_range(0, 4));
      bus.startOfFrame = ($urandom_range(0, 2) == 0);
`ifdef COUNTDOWN_ABORT_EN
      bus.abort = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
